route_sequencer: RTL and testbench
==================================

# route_sequencer

Command-side counterpart of the tracker turn detectors (`turn_LEFT` / `turn_RIGHT`). It holds a short queue of route commands (straight, left, right or stop, each with a line-crossing count) and drives the car forward until the tracker reports a junction. At each junction it either passes straight through or requests a turn by asserting `enL`/`enR` with `count`, then waits for `doneL`/`doneR`. It sits between the top-level control/UI and the motor and turn blocks, and owns per-leg timeout and error reporting.

## Interface
Parameters:
- `DEPTH`, 8: route queue entries; power of two, minimum 2.
- `TIMEOUT`, 100_000_000: cycles allowed per FWD leg or TURN before an error (1 s at 100 MHz).

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `cmd_wr`  in  1  write `cmd_in` into the queue.
- `cmd_in`  in  4  `{dir[1:0], cnt[1:0]}`; dir 00 = STRAIGHT, 01 = LEFT, 10 = RIGHT, 11 = STOP.
- `start`  in  1  begin route (IDLE), or clear an error (ERROR).
- `detect`  in  3  tracker bits; 3'b111 = junction/black line.
- `doneL`, `doneR`  in  1 each  turn complete, from the turn blocks.
- `err_in`  in  1  error flag from a turn block.
- `enL`, `enR`  out  1 each  turn request.
- `count`  out  2  line crossings for the active turn.
- `motor`  out  2  00 = STOP, 01 = FWD, 10 = LEFT, 11 = RIGHT.
- `busy`  out  1  route in progress.
- `finished`  out  1  one-cycle pulse when the route completes.
- `error`  out  1  sticky error flag.
- `level`  out  $clog2(DEPTH)+1  number of queued commands.

## Operation
- Queue: circular FIFO with read and write pointers plus a level counter.
  - `cmd_wr` is accepted only in IDLE with level < DEPTH.
  - A write while full or not in IDLE is dropped silently.
  - The head entry is popped only when its command completes.
- States and transitions:
  - IDLE: `motor` = STOP, `busy` = 0. `start` with level > 0 goes to FWD. `start` with level = 0 is ignored.
  - FWD: `motor` = FWD. On the rising edge of (`detect` == 111), using a registered previous-junction bit:
    - head dir STRAIGHT goes to PASS.
    - head dir LEFT or RIGHT goes to TURN.
    - head dir STOP pops the entry and goes to DONE.
  - PASS: `motor` = FWD. When `detect` != 111: pop, then go to NEXT.
  - TURN: `enL` (LEFT) or `enR` (RIGHT) = 1, `count` = head cnt, `motor` = LEFT or RIGHT. The matching done signal goes to SETTLE. The non-matching done signal is ignored.
  - SETTLE: enables = 0, `motor` = FWD, pop. Lasts one cycle, then goes to NEXT.
  - NEXT: level = 0 goes to DONE, otherwise to FWD.
  - DONE: `finished` = 1 for one cycle, `motor` = STOP, then IDLE.
  - ERROR: enables = 0, `motor` = STOP, `error` = 1. `start` flushes the queue (pointers and level to 0), clears `error`, and goes to IDLE.
- Timeout: a leg counter clears on every state entry and increments in FWD and TURN. When it reaches TIMEOUT−1, go to ERROR.
- `err_in` = 1 in TURN goes to ERROR. In any other state it is ignored.
- `count` holds its last value outside TURN; reset value is 0.

## Timing
- All outputs are registered and reflect the current state. The first cycle of a new state shows that state's outputs.
- Reset values:
  - `motor` = 00, `enL` = `enR` = 0, `count` = 0.
  - `busy` = 0, `finished` = 0, `error` = 0, `level` = 0.
  - State = IDLE, previous-junction bit = 0.
- Reset asserted mid-route returns to IDLE immediately and empties the queue.
- `start` sampled in IDLE: FWD is entered the next cycle, and `busy` = 1 from that cycle through DONE.
- Junction response: a junction edge sampled at cycle N puts the block in TURN, with `enL`/`enR` high, at cycle N+1.
- Done response: `doneL` sampled high at cycle M drops `enL` at M+1 (SETTLE) and enters NEXT at M+2.
- `detect` == 111 already present on FWD entry is not an edge; the car must leave the junction before a new edge can count.
- `level` updates the cycle after a write or pop.
- `finished` and `error` are never high in the same cycle.

## Test plan
1. Load `{01,2'd2}`, `{11,0}`; pulse `start`; drive `detect` 000→111; hold `doneL` = 1 → `enL` = 1, `count` = 2, `motor` = LEFT; then SETTLE, FWD; next junction gives a `finished` pulse; final `level` = 0.
2. Load STRAIGHT, then RIGHT cnt 1 → first junction: `motor` stays FWD and no enable asserts; after `detect` clears, the second junction asserts `enR` = 1 with `count` = 1.
3. Write 9 commands with DEPTH = 8 → `level` = 8; the ninth is dropped; `cmd_wr` while busy is dropped.
4. TIMEOUT = 16, no junction → ERROR at cycle 16 after FWD entry, `motor` = 00; `start` clears `error` with `level` = 0.
5. `err_in` pulse during TURN → ERROR next cycle, `enL` = 0.
6. Assert `rst` = 0 during TURN → all outputs take reset values immediately, state = IDLE, `level` = 0.

Source files
------------

// File: rtl/route_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : route_sequencer
//  Brief    : Route command queue and sequencer. Drives the car forward
//             between junctions and, at each junction, passes straight,
//             requests a left/right turn from the turn blocks, or stops.
//             Owns the per-leg timeout and the sticky error flag.
//  Revision : 1.0  initial release
// ============================================================================
module route_sequencer #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 100_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_wr,
  input  logic [3:0]               cmd_in,
  input  logic                     start,
  input  logic [2:0]               detect,
  input  logic                     doneL,
  input  logic                     doneR,
  input  logic                     err_in,
  output logic                     enL,
  output logic                     enR,
  output logic [1:0]               count,
  output logic [1:0]               motor,
  output logic                     busy,
  output logic                     finished,
  output logic                     error,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int LEG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LEG_W-1:0] LEG_LAST = LEG_W'(TIMEOUT - 1);

  localparam logic [1:0] DIR_STRAIGHT = 2'b00;
  localparam logic [1:0] DIR_LEFT     = 2'b01;
  localparam logic [1:0] DIR_RIGHT    = 2'b10;

  localparam logic [1:0] MOTOR_STOP  = 2'b00;
  localparam logic [1:0] MOTOR_FWD   = 2'b01;
  localparam logic [1:0] MOTOR_LEFT  = 2'b10;
  localparam logic [1:0] MOTOR_RIGHT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FWD    = 3'd1,
    S_PASS   = 3'd2,
    S_TURN   = 3'd3,
    S_SETTLE = 3'd4,
    S_NEXT   = 3'd5,
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic               jprev_q, jprev_d;
  logic [LEG_W-1:0]   leg_q, leg_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [1:0]         motor_q, motor_d;
  logic [1:0]         count_q, count_d;
  logic               enl_q, enl_d;
  logic               enr_q, enr_d;
  logic               busy_q, busy_d;
  logic               finished_q, finished_d;
  logic               error_q, error_d;

  logic [3:0]         mem_q [DEPTH];

  logic               junction;
  logic               junction_edge;
  logic [3:0]         head;
  logic [1:0]         head_dir;
  logic [1:0]         head_cnt;
  logic               leg_expired;
  logic               turn_done;
  logic               do_write;
  logic               do_pop;
  logic               flush;

  assign junction      = (detect == 3'b111);
  assign junction_edge = junction && !jprev_q;
  assign head          = mem_q[rd_ptr_q];
  assign head_dir      = head[3:2];
  assign head_cnt      = head[1:0];
  assign leg_expired   = (leg_q == LEG_LAST);
  assign turn_done     = ((head_dir == DIR_LEFT) && doneL) ||
                         ((head_dir == DIR_RIGHT) && doneR);
  assign do_write      = cmd_wr && (state_q == S_IDLE) && (level_q < LVL_FULL);

  // Next-state decision: route sequencing, pops and error entry
  always_comb begin
    state_d = state_q;
    do_pop  = 1'b0;
    flush   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && (level_q != '0)) state_d = S_FWD;
      end
      S_FWD: begin
        if (leg_expired) begin
          state_d = S_ERROR;
        end else if (junction_edge) begin
          case (head_dir)
            DIR_STRAIGHT: state_d = S_PASS;
            DIR_LEFT,
            DIR_RIGHT:    state_d = S_TURN;
            default: begin
              do_pop  = 1'b1;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_PASS: begin
        // Wait for the car to leave the junction before retiring the entry
        if (!junction) begin
          do_pop  = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_TURN: begin
        if (err_in)           state_d = S_ERROR;
        else if (turn_done)   state_d = S_SETTLE;
        else if (leg_expired) state_d = S_ERROR;
      end
      S_SETTLE: begin
        do_pop  = 1'b1;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        state_d = (level_q == '0) ? S_DONE : S_FWD;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERROR: begin
        if (start) begin
          flush   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Queue bookkeeping; writes happen only in IDLE and pops never do
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else if (do_write) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      level_d  = level_q + 1'b1;
    end else if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      level_d  = level_q - 1'b1;
    end
  end

  // Leg timer restarts on every state change and runs in FWD and TURN
  always_comb begin
    jprev_d = junction;
    if (state_d != state_q) begin
      leg_d = '0;
    end else if ((state_q == S_FWD) || (state_q == S_TURN)) begin
      leg_d = leg_q + 1'b1;
    end else begin
      leg_d = leg_q;
    end
  end

  // Outputs decoded from the next state so they line up with it once registered
  always_comb begin
    motor_d    = MOTOR_STOP;
    enl_d      = 1'b0;
    enr_d      = 1'b0;
    busy_d     = 1'b0;
    finished_d = 1'b0;
    error_d    = 1'b0;
    count_d    = count_q;
    case (state_d)
      S_FWD, S_PASS, S_SETTLE, S_NEXT: begin
        motor_d = MOTOR_FWD;
        busy_d  = 1'b1;
      end
      S_TURN: begin
        busy_d  = 1'b1;
        count_d = head_cnt;
        if (head_dir == DIR_LEFT) begin
          enl_d   = 1'b1;
          motor_d = MOTOR_LEFT;
        end else begin
          enr_d   = 1'b1;
          motor_d = MOTOR_RIGHT;
        end
      end
      S_DONE: begin
        busy_d     = 1'b1;
        finished_d = 1'b1;
      end
      S_ERROR: begin
        error_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State, queue pointers, leg timer and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      jprev_q    <= 1'b0;
      leg_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      motor_q    <= MOTOR_STOP;
      count_q    <= 2'b00;
      enl_q      <= 1'b0;
      enr_q      <= 1'b0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      jprev_q    <= jprev_d;
      leg_q      <= leg_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      motor_q    <= motor_d;
      count_q    <= count_d;
      enl_q      <= enl_d;
      enr_q      <= enr_d;
      busy_q     <= busy_d;
      finished_q <= finished_d;
      error_q    <= error_d;
    end
  end

  // Command storage; contents are only meaningful below the level count
  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_ptr_q] <= cmd_in;
  end

  assign motor    = motor_q;
  assign count    = count_q;
  assign enL      = enl_q;
  assign enR      = enr_q;
  assign busy     = busy_q;
  assign finished = finished_q;
  assign error    = error_q;
  assign level    = level_q;

endmodule
`default_nettype wire

// File: tb/tb_route_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_route_sequencer
//  Brief    : Self-checking bench for route_sequencer: vector table for a
//             full left-turn route, directed corner sequences, and random
//             routes checked against a command-queue reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_route_sequencer;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_wr = 1'b0;
  logic [3:0]    cmd_in = 4'd0;
  logic          start = 1'b0;
  logic [2:0]    detect = 3'd0;
  logic          doneL = 1'b0;
  logic          doneR = 1'b0;
  logic          err_in = 1'b0;
  logic          enL, enR, busy, finished, error;
  logic [1:0]    count, motor;
  logic [LW-1:0] level;

  route_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cmd_wr(cmd_wr), .cmd_in(cmd_in), .start(start),
    .detect(detect), .doneL(doneL), .doneR(doneR), .err_in(err_in),
    .enL(enL), .enR(enR), .count(count), .motor(motor), .busy(busy),
    .finished(finished), .error(error), .level(level)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [3:0] mq[$];

  typedef struct {
    logic       wr;
    logic [3:0] cmd;
    logic       st;
    logic [2:0] det;
    logic       dl, dr, ei;
    logic [1:0] m;
    logic       el, er;
    logic [1:0] c;
    logic       b, f, e;
    logic [LW-1:0] l;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(logic wr, logic [3:0] cmd, logic st, logic [2:0] det,
                              logic dl, logic dr, logic ei, logic [1:0] m, logic el,
                              logic er, logic [1:0] c, logic b, logic f, logic e,
                              logic [LW-1:0] l);
    vec_t v;
    v.wr = wr; v.cmd = cmd; v.st = st; v.det = det; v.dl = dl; v.dr = dr; v.ei = ei;
    v.m = m; v.el = el; v.er = er; v.c = c; v.b = b; v.f = f; v.e = e; v.l = l;
    return v;
  endfunction

  function automatic logic [31:0] pk(logic [1:0] m, logic el, logic er, logic [1:0] c,
                                     logic b, logic f, logic e, logic [LW-1:0] l);
    return {19'd0, m, el, er, c, b, f, e, l};
  endfunction

  function automatic logic [31:0] outs();
    return pk(motor, enL, enR, count, busy, finished, error, level);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    cmd_wr = 1'b0; cmd_in = 4'd0; start = 1'b0; detect = 3'd0;
    doneL = 1'b0; doneR = 1'b0; err_in = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    mq.delete();
  endtask

  task automatic write_cmd(input logic [3:0] c);
    cmd_wr = 1'b1; cmd_in = c;
    tick();
    cmd_wr = 1'b0;
  endtask

  initial begin
    logic [3:0] c;
    logic [1:0] dir;
    int         nw, k, h, v;
    bit         route_over;

    // Reset state
    @(negedge clk);
    chk("reset_outputs", outs(), 32'd0);
    rst = 1'b1;

    // Full left-turn route, one vector per cycle
    tbl[0]  = mk(1, 4'b0110, 0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'd0, 0, 0, 0, 1);
    tbl[1]  = mk(1, 4'b1100, 0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'd0, 0, 0, 0, 2);
    tbl[2]  = mk(0, 4'b0000, 1, 3'b000, 0, 0, 0, 2'b01, 0, 0, 2'd0, 1, 0, 0, 2);
    tbl[3]  = mk(0, 4'b0000, 0, 3'b000, 0, 0, 0, 2'b01, 0, 0, 2'd0, 1, 0, 0, 2);
    tbl[4]  = mk(0, 4'b0000, 0, 3'b111, 0, 0, 0, 2'b10, 1, 0, 2'd2, 1, 0, 0, 2);
    tbl[5]  = mk(0, 4'b0000, 0, 3'b111, 0, 1, 0, 2'b10, 1, 0, 2'd2, 1, 0, 0, 2);
    tbl[6]  = mk(0, 4'b0000, 0, 3'b111, 1, 0, 0, 2'b01, 0, 0, 2'd2, 1, 0, 0, 2);
    tbl[7]  = mk(0, 4'b0000, 0, 3'b111, 1, 0, 0, 2'b01, 0, 0, 2'd2, 1, 0, 0, 1);
    tbl[8]  = mk(0, 4'b0000, 0, 3'b111, 0, 0, 0, 2'b01, 0, 0, 2'd2, 1, 0, 0, 1);
    tbl[9]  = mk(0, 4'b0000, 0, 3'b111, 0, 0, 0, 2'b01, 0, 0, 2'd2, 1, 0, 0, 1);
    tbl[10] = mk(0, 4'b0000, 0, 3'b000, 0, 0, 0, 2'b01, 0, 0, 2'd2, 1, 0, 0, 1);
    tbl[11] = mk(0, 4'b0000, 0, 3'b111, 0, 0, 0, 2'b00, 0, 0, 2'd2, 1, 1, 0, 0);
    tbl[12] = mk(0, 4'b0000, 0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'd2, 0, 0, 0, 0);

    for (int i = 0; i < 13; i++) begin
      cmd_wr = tbl[i].wr; cmd_in = tbl[i].cmd; start = tbl[i].st; detect = tbl[i].det;
      doneL = tbl[i].dl; doneR = tbl[i].dr; err_in = tbl[i].ei;
      tick();
      chk($sformatf("vec%0d", i), outs(),
          pk(tbl[i].m, tbl[i].el, tbl[i].er, tbl[i].c, tbl[i].b, tbl[i].f, tbl[i].e, tbl[i].l));
    end

    // Queue full: ninth write dropped, write while busy dropped, head intact
    do_reset();
    for (int i = 0; i < 9; i++) write_cmd(4'(i));
    chk("full_level", 32'(level), 32'd8);
    start = 1'b1; tick(); start = 1'b0;
    write_cmd(4'b1000);
    chk("busy_write_drop", 32'(level), 32'd8);
    detect = 3'b111; tick();
    chk("full_head_straight", {motor, enL, enR}, {2'b01, 1'b0, 1'b0});

    // Leg timeout with no junction
    do_reset();
    write_cmd(4'b0101);
    start = 1'b1; tick(); start = 1'b0;
    repeat (TIMEOUT - 1) tick();
    chk("timeout_before", {error, motor}, {1'b0, 2'b01});
    tick();
    chk("timeout_error", {error, finished, motor, enL, enR}, {1'b1, 1'b0, 2'b00, 1'b0, 1'b0});
    write_cmd(4'b0000);
    chk("error_write_drop", 32'(level), 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("error_clear", {error, busy, motor, level}, {1'b0, 1'b0, 2'b00, LW'(0)});

    // err_in ignored in FWD, honoured in TURN
    do_reset();
    write_cmd(4'b0111);
    start = 1'b1; tick(); start = 1'b0;
    err_in = 1'b1; tick(); err_in = 1'b0;
    chk("err_in_fwd_ignored", {error, motor}, {1'b0, 2'b01});
    detect = 3'b111; tick();
    chk("err_turn_entry", {motor, enL, count}, {2'b10, 1'b1, 2'd3});
    err_in = 1'b1; tick(); err_in = 1'b0;
    chk("err_in_turn", {error, finished, enL, motor}, {1'b0 ^ 1'b1, 1'b0, 1'b0, 2'b00});
    start = 1'b1; tick(); start = 1'b0; detect = 3'b000;
    chk("err_in_clear", {error, level}, {1'b0, LW'(0)});

    // Asynchronous reset during TURN
    do_reset();
    write_cmd(4'b1001);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    detect = 3'b111; tick();
    chk("rst_turn_entry", {motor, enR, count}, {2'b11, 1'b1, 2'd1});
    rst = 1'b0;
    #1;
    chk("rst_async", outs(), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("rst_idle", outs(), 32'd0);

    // Random routes against the queue model
    do_reset();
    for (int r = 0; r < 30; r++) begin
      nw = $urandom_range(0, 10);
      for (int i = 0; i < nw; i++) begin
        v = $urandom_range(0, 9);
        dir = (v < 3) ? 2'b00 : (v < 6) ? 2'b01 : (v < 9) ? 2'b10 : 2'b11;
        c = {dir, 2'($urandom_range(0, 3))};
        write_cmd(c);
        if (mq.size() < DEPTH) mq.push_back(c);
      end
      chk("rnd_load_level", 32'(level), 32'(mq.size()));
      start = 1'b1; tick(); start = 1'b0;
      if (mq.size() == 0) begin
        chk("rnd_start_empty", {busy, motor}, {1'b0, 2'b00});
        continue;
      end
      chk("rnd_start", {busy, motor}, {1'b1, 2'b01});
      route_over = 1'b0;
      while (!route_over) begin
        c = mq.pop_front();
        k = $urandom_range(1, 5);
        repeat (k) begin
          detect = 3'($urandom_range(0, 6));
          err_in = ($urandom_range(0, 3) == 0);
          tick();
        end
        err_in = 1'b0;
        chk("rnd_approach", {motor, enL, enR}, {2'b01, 1'b0, 1'b0});
        detect = 3'b111; tick();
        h = $urandom_range(0, 3);
        if (c[3:2] == 2'b11) begin
          chk("rnd_stop", {finished, motor, level}, {1'b1, 2'b00, LW'(mq.size())});
          route_over = 1'b1;
        end else begin
          if (c[3:2] == 2'b00) begin
            chk("rnd_pass", {motor, enL, enR}, {2'b01, 1'b0, 1'b0});
            repeat (h) tick();
            detect = 3'($urandom_range(0, 6));
          end else begin
            chk("rnd_turn", {motor, enL, enR, count},
                {(c[3:2] == 2'b01) ? 2'b10 : 2'b11, c[3:2] == 2'b01, c[3:2] == 2'b10, c[1:0]});
            repeat (h) begin
              if (c[3:2] == 2'b01) doneR = 1'($urandom_range(0, 1));
              else                 doneL = 1'($urandom_range(0, 1));
              tick();
            end
            doneL = (c[3:2] == 2'b01);
            doneR = (c[3:2] == 2'b10);
            tick();
            chk("rnd_settle", {motor, enL, enR, count}, {2'b01, 1'b0, 1'b0, c[1:0]});
            doneL = 1'b0; doneR = 1'b0;
            detect = 3'($urandom_range(0, 6));
          end
          tick();
          chk("rnd_next_level", {motor, level}, {2'b01, LW'(mq.size())});
          tick();
          if (mq.size() == 0) begin
            chk("rnd_finish", {finished, error, motor}, {1'b1, 1'b0, 2'b00});
            route_over = 1'b1;
          end else begin
            chk("rnd_continue", {finished, busy, motor}, {1'b0, 1'b1, 2'b01});
          end
        end
      end
      tick();
      chk("rnd_idle", {busy, finished, level}, {1'b0, 1'b0, LW'(mq.size())});
      detect = 3'b000;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
